feedbackloop_comb_decim: RTL and testbench

- Downstream stage of the 8-bit signed running-sum accumulator (integrator).
- Decimates the accumulator's output stream by RATIO and emits the difference between consecutive retained samples (integrate-and-dump / single-stage CIC comb).
- Results leave through a valid/ready interface backed by a 2-entry output buffer.
- Overrun is flagged when the consumer stalls too long.

---
 rtl/feedbackloop_comb_decim.sv | 99 +++++++++
 tb/tb_feedbackloop_comb_decim.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/feedbackloop_comb_decim.sv
// Decimating comb stage behind the running-sum accumulator: it keeps every RATIO-th sample and
// emits the wrapped difference from the previous kept sample through a 2-entry valid/ready buffer.
// Optional macro FEEDBACKLOOP_COMB_SCALE_EN divides each difference by RATIO (RATIO must be a power of two).
module feedbackloop_comb_decim #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic [WIDTH-1:0] acc_i,
    input  logic             acc_valid_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             overrun_o
);

    localparam int PW = $clog2(RATIO);
    localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);

    logic [PW-1:0]    phase_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             overrun_q;
    logic             capture;
    logic             pop;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] push_data;

    assign capture = acc_valid_i && (phase_q == LAST_PHASE);
    assign pop     = (count_q != 2'd0) && out_ready_i;
    // Wrapping subtraction cancels the integrator's own wrap whenever the true step fits in WIDTH.
    assign diff    = acc_i - prev_q;

`ifdef FEEDBACKLOOP_COMB_SCALE_EN
    if ((1 << PW) != RATIO) begin : g_ratio_check
        $error("feedbackloop_comb_decim: RATIO must be a power of two when scaling is enabled");
    end
    assign push_data = $signed(diff) >>> PW;
`else
    assign push_data = diff;
`endif

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign overrun_o   = overrun_q;

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            phase_q   <= '0;
            prev_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            overrun_q <= 1'b0;
        end else begin
            if (acc_valid_i) begin
                phase_q <= capture ? '0 : phase_q + 1'b1;
            end
            if (capture) begin
                prev_q <= acc_i;
            end
            // The head register doubles as the output, so it only moves on a real push or pop.
            case (count_q)
                2'd0: begin
                    if (capture) begin
                        head_q  <= push_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (capture && pop) begin
                        head_q <= push_data;
                    end else if (capture) begin
                        tail_q  <= push_data;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (capture) begin
                            tail_q <= push_data;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end else if (capture) begin
                        overrun_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feedbackloop_comb_decim.sv
// Self-checking bench for feedbackloop_comb_decim: directed scenarios plus random traffic, all
// compared against a queue-based model of decimation, differencing and the 2-deep output buffer.
module tb_feedbackloop_comb_decim;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;
`ifdef FEEDBACKLOOP_COMB_SCALE_EN
    localparam int SHIFT = $clog2(RATIO);
`else
    localparam int SHIFT = 0;
`endif

    logic             system1000;
    logic             system1000_rst;
    logic [WIDTH-1:0] acc_i;
    logic             acc_valid_i;
    logic [WIDTH-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             overrun_o;

    int checks;
    int failures;

    logic [WIDTH-1:0] m_queue[$];
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_prev;
    int               m_nvalid;
    logic             m_overrun;

    feedbackloop_comb_decim #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .acc_i          (acc_i),
        .acc_valid_i    (acc_valid_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .overrun_o      (overrun_o)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] scaled(input logic [WIDTH-1:0] d);
        int v;
        v = int'($signed(d));
        v = v >>> SHIFT;
        return v[WIDTH-1:0];
    endfunction

    task automatic modelReset();
        m_queue.delete();
        m_last    = '0;
        m_prev    = '0;
        m_nvalid  = 0;
        m_overrun = 1'b0;
    endtask

    // Every RATIO-th valid sample is kept and differenced against the previous kept one.
    task automatic modelStep(input logic v, input logic [WIDTH-1:0] a, input logic r);
        int               size_before;
        logic             do_pop;
        logic             do_push;
        logic [WIDTH-1:0] val;
        size_before = m_queue.size();
        do_pop      = (size_before != 0) && r;
        do_push     = 1'b0;
        val         = '0;
        if (v) begin
            m_nvalid++;
            if (m_nvalid % RATIO == 0) begin
                do_push = 1'b1;
                val     = scaled(a - m_prev);
                m_prev  = a;
            end
        end
        if (do_pop) m_last = m_queue.pop_front();
        if (do_push) begin
            if (size_before == 2 && !do_pop) m_overrun = 1'b1;
            else m_queue.push_back(val);
        end
    endtask

    function automatic logic [WIDTH-1:0] modelHead();
        return (m_queue.size() != 0) ? m_queue[0] : m_last;
    endfunction

    task automatic compareAll(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'(m_queue.size() != 0));
        checkOutput({tag, "_data"}, 32'(out_data_o), 32'(modelHead()));
        checkOutput({tag, "_overrun"}, 32'(overrun_o), 32'(m_overrun));
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [WIDTH-1:0] a, input logic r);
        @(negedge system1000);
        acc_valid_i = v;
        acc_i       = a;
        out_ready_i = r;
        modelStep(v, a, r);
        @(posedge system1000);
        #1;
        compareAll(tag);
    endtask

    // Reset is raised between edges so its asynchronous effect is observed before any clock.
    task automatic pulseReset(input string tag);
        @(negedge system1000);
        acc_valid_i    = 1'b0;
        out_ready_i    = 1'b0;
        #1;
        system1000_rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, "_rst_valid"}, 32'(out_valid_o), 32'd0);
        checkOutput({tag, "_rst_data"}, 32'(out_data_o), 32'd0);
        checkOutput({tag, "_rst_overrun"}, 32'(overrun_o), 32'd0);
        @(negedge system1000);
        system1000_rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] wrap_vals[8];
        logic [WIDTH-1:0] rv;
        checks         = 0;
        failures       = 0;
        system1000_rst = 1'b1;
        acc_i          = '0;
        acc_valid_i    = 1'b0;
        out_ready_i    = 1'b0;
        modelReset();
        wrap_vals = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'h8C, 8'hA0};

        repeat (2) @(posedge system1000);
        #1;
        checkOutput("reset_valid", 32'(out_valid_o), 32'd0);
        checkOutput("reset_data", 32'(out_data_o), 32'd0);
        checkOutput("reset_overrun", 32'(overrun_o), 32'd0);
        @(negedge system1000);
        system1000_rst = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            applyStimulus("step", 1'b1, WIDTH'(3 * i), 1'b1);
            if (i == 4 || i == 8) begin
                checkOutput("step_value", 32'(out_data_o), 32'(scaled(8'd12)));
                checkOutput("step_present", 32'(out_valid_o), 32'd1);
            end
        end
        applyStimulus("step_idle", 1'b0, '0, 1'b1);

        pulseReset("pre_wrap");
        for (int i = 0; i < 8; i++) begin
            applyStimulus("wrap", 1'b1, wrap_vals[i], 1'b1);
            if (i == 3 || i == 7) checkOutput("wrap_value", 32'(out_data_o), 32'(scaled(8'd80)));
        end

        pulseReset("pre_sparse");
        for (int i = 0; i < 8; i++) begin
            applyStimulus("sparse", 1'b1, wrap_vals[i], 1'b1);
            applyStimulus("sparse_gap", 1'b0, WIDTH'($urandom), 1'b1);
        end

        pulseReset("pre_bp");
        for (int i = 1; i <= 12; i++) applyStimulus("bp", 1'b1, WIDTH'(5 * i), 1'b0);
        checkOutput("bp_overrun_set", 32'(overrun_o), 32'd1);
        checkOutput("bp_head_value", 32'(out_data_o), 32'(scaled(8'd20)));
        for (int i = 0; i < 4; i++) applyStimulus("bp_drain", 1'b0, '0, 1'b1);
        checkOutput("bp_drained", 32'(out_valid_o), 32'd0);

        pulseReset("pre_full");
        for (int i = 1; i <= 11; i++) applyStimulus("full_fill", 1'b1, WIDTH'(5 * i), 1'b0);
        applyStimulus("full_pushpop", 1'b1, WIDTH'(60), 1'b1);
        checkOutput("full_no_overrun", 32'(overrun_o), 32'd0);
        checkOutput("full_still_valid", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus("full_drain", 1'b0, '0, 1'b1);

        pulseReset("pre_mid");
        for (int i = 1; i <= 6; i++) applyStimulus("mid_fill", 1'b1, WIDTH'(9 * i), 1'b0);
        pulseReset("mid");
        for (int i = 1; i <= 4; i++) applyStimulus("mid_after", 1'b1, WIDTH'(7 * i), 1'b1);
        checkOutput("mid_value", 32'(out_data_o), 32'(scaled(8'd28)));
        applyStimulus("mid_idle", 1'b0, '0, 1'b1);
        checkOutput("mid_single", 32'(out_valid_o), 32'd0);

        pulseReset("pre_rand");
        rv = '0;
        for (int i = 0; i < 600; i++) begin
            rv = rv + WIDTH'($urandom_range(0, 60));
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), rv, 1'($urandom_range(0, 4) > 1));
            if (i == 300) pulseReset("rand_mid");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
